// File: rtl/mantle_concat_pkg.sv
// Shared types and helpers for the concat sequencer.
// Optional feature macro: MANTLE_CONCAT_SEQ_OVERLAP_EN (see mantle_concat_sequencer.sv).
package mantle_concat_pkg;

    typedef enum logic [0:0] {IDLE, EMIT} state_e;

    localparam int unsigned DefaultWidth = 32;

    // Index width for an n-word array, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mantle_concat_sequencer_if.sv
// Handshake bundle for the concat sequencer: array pair in, word stream out.
// Optional feature macro: MANTLE_CONCAT_SEQ_OVERLAP_EN (affects in_ready timing only).
interface mantle_concat_sequencer_if
    import mantle_concat_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned N1    = 9,
    parameter int unsigned N2    = 6
);

    localparam int unsigned IW = idx_width(N1 + N2);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1 [N1];
    logic [WIDTH-1:0] in2 [N2];
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0]    out_index;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, busy
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, busy
    );

endinterface

// File: rtl/mantle_concat_flat.sv
// Combinational concatenation of in1 and in2 into one N1+N2 word array.
// Optional feature macro: MANTLE_CONCAT_SEQ_OVERLAP_EN (not used here).
module mantle_concat_flat #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N1    = 9,
    parameter int unsigned N2    = 6
) (
    input  logic [WIDTH-1:0] in1  [N1],
    input  logic [WIDTH-1:0] in2  [N2],
    output logic [WIDTH-1:0] flat [N1+N2]
);

    for (genvar k = 0; k < N1; k++) begin : g_in1
        assign flat[k] = in1[k];
    end

    for (genvar k = 0; k < N2; k++) begin : g_in2
        assign flat[N1+k] = in2[k];
    end

endmodule

// File: rtl/mantle_concat_sequencer.sv
// Captures an in1/in2 pair and streams in1[0..N1-1] then in2[0..N2-1] one word per beat.
// Define MANTLE_CONCAT_SEQ_OVERLAP_EN to accept the next pair on the last beat (no bubble).
module mantle_concat_sequencer
    import mantle_concat_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned N1    = 9,
    parameter int unsigned N2    = 6
) (
    input logic                  CLK,
    input logic                  ASYNCRESET,
    mantle_concat_sequencer_if.slave bus
);

    localparam int unsigned NT = N1 + N2;
    localparam int unsigned IW = idx_width(NT);
    localparam logic [IW-1:0] LastIdx = IW'(NT - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] bank_q [NT];
    logic [WIDTH-1:0] flat   [NT];
    logic             load;
    logic             emit;
    logic             at_last;
    logic             in_ready;

    mantle_concat_flat #(
        .WIDTH (WIDTH),
        .N1    (N1),
        .N2    (N2)
    ) u_flat (
        .in1  (bus.in1),
        .in2  (bus.in2),
        .flat (flat)
    );

    assign emit    = (state_q == EMIT);
    assign at_last = (idx_q == LastIdx);

`ifdef MANTLE_CONCAT_SEQ_OVERLAP_EN
    assign in_ready = (state_q == IDLE) || (emit && at_last && bus.out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = emit;
        bus.busy      = emit;
        bus.out_index = idx_q;
        bus.out_last  = emit && at_last;
        // Gate the data lane so IDLE presents zero rather than a stale word.
        bus.out_data  = emit ? bank_q[idx_q] : '0;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = EMIT;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (at_last) begin
                        idx_d = '0;
                        // in_ready is only high here when overlap is compiled in.
                        if (bus.in_valid && in_ready) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int k = 0; k < NT; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                for (int k = 0; k < NT; k++) begin
                    bank_q[k] <= flat[k];
                end
            end
        end
    end

endmodule

// File: doc/mantle_concat_sequencer.md
# mantle_concat_sequencer

Sequencer that serialises the concatenation of two word arrays onto a single-word output stream. Captures an `in1`/`in2` array pair on a valid/ready handshake, then emits one word per accepted beat: `in1[0..N1-1]`, then `in2[0..N2-1]`, with index and last-beat flags. Sits between array-producing datapath stages and narrow word-serial consumers, sharing one output word lane across the concatenated result.

## Interface

**Parameters**
- `WIDTH`, default 32: word width in bits.
- `N1`, default 9: word count of `in1`; must be ≥ 1.
- `N2`, default 6: word count of `in2`; must be ≥ 1.

**Ports**
- `CLK` in 1: clock; all state updates on the rising edge.
- `ASYNCRESET` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in1`/`in2` pair is valid.
- `in_ready` out 1: sequencer accepts a pair this cycle.
- `in1` in `[WIDTH-1:0] [N1-1:0]` (unpacked): first array.
- `in2` in `[WIDTH-1:0] [N2-1:0]` (unpacked): second array.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out WIDTH: current word.
- `out_index` out `$clog2(N1+N2)`: position of `out_data` in the concatenated array.
- `out_last` out 1: current word is index `N1+N2-1`.
- `busy` out 1: a captured pair is still being emitted.

## Operation

- **Storage.** One register bank of `N1+N2` words holds the concatenation. Word `k < N1` is `in1[k]`; word `k ≥ N1` is `in2[k-N1]`.
- **States.**
  - `IDLE`: `in_ready=1`, `out_valid=0`.
  - `EMIT`: `out_valid=1`, `out_data = bank[idx]`, `out_index = idx`.
- **Transitions.**
  - `IDLE` → `EMIT` on `in_valid && in_ready`. The bank loads and `idx` is set to 0.
  - In `EMIT`, each `out_valid && out_ready` increments `idx`.
  - At `idx = N1+N2-1`, that handshake returns the block to `IDLE`, or reloads (see Configuration).
- **Stall.** While `out_ready=0`, `out_data`, `out_index` and `out_last` hold stable. The bank is never written during `EMIT`, except by an overlapped load.
- **Index.** `idx` is an unsigned counter. It never exceeds `N1+N2-1`; there is no wrap past last.
- **Derived outputs.**
  - `out_last = (idx == N1+N2-1) && out_valid`.
  - `busy = (state == EMIT)`.
- **Input handshake.** `in_valid` with `in_ready=0` is held off. The producer must keep its data stable until accepted.
- **Reset values.**
  - State `IDLE`, `idx = 0`, bank = 0.
  - `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_index = 0`, `out_last = 0`, `busy = 0`.
- **Reset mid-stream.** The in-flight pair is discarded. All outputs return to reset values asynchronously.

## Timing

- Input handshake at edge t: `out_valid=1` with word 0 from t+1. This is a one-cycle latency.
- With `out_ready` held high, a full pair takes N1+N2 cycles.
- Non-overlapped throughput is one pair per N1+N2+1 cycles; `IDLE` costs one cycle.
- All outputs are registered or decode registered state. There is no combinational path from `out_ready` or `in_valid` to any output, except `in_ready` under the macro.

## Configuration

- **`MANTLE_CONCAT_SEQ_OVERLAP_EN` defined:**
  - `in_ready` is also asserted in `EMIT` when `out_ready && out_last`.
  - A pair accepted on that edge reloads the bank, sets `idx=0` and stays in `EMIT`.
  - Throughput is one pair per N1+N2 cycles with no bubble.
- **Undefined:**
  - `in_ready = (state == IDLE)` only.
  - The last beat always returns to `IDLE`.

## Structure

- **Package `mantle_concat_pkg`:**
  - State enum `{IDLE, EMIT}`.
  - Default `WIDTH` constant.
  - Function for index width (`$clog2(N1+N2)`, minimum 1).
- **Sub-module `mantle_concat_flat`:** combinational concatenation of `in1`/`in2` into an `N1+N2` array. It feeds the bank load.
- The sequencer holds the FSM, counter, bank and output mux.

## Test plan

- **Basic pair.** After reset, `in1[k]=32'h100+k`, `in2[k]=32'h200+k`, `out_ready=1`.
  - `out_valid` rises one cycle after the handshake.
  - Words `0x100..0x108` then `0x200..0x205`, `out_index` 0..14, `out_last` only on index 14.
  - `in_ready` returns to 1 the cycle after.
- **Stall.** Toggle `out_ready` low for 3 cycles at index 4.
  - `out_data=0x104` and `out_index=4` hold.
  - No word is skipped or duplicated.
- **Back-pressure on input.** Assert `in_valid` during `EMIT` with a new pair.
  - Without the macro: not accepted until `IDLE`; the first pair completes unchanged.
- **Overlap (macro on).** Two pairs presented back-to-back, `out_ready=1`.
  - Second pair's word 0 appears the cycle after the first pair's `out_last`.
  - 30 words in 30 cycles.
- **Reset mid-stream.** Assert `ASYNCRESET` at index 7.
  - Outputs go to reset values immediately.
  - After release, a new pair streams from index 0.
- **Reset values.** Check every output immediately after reset deassert: `in_ready=1`, all others 0.
